// File: rtl/audio_serial_parallel_serdes_if.sv
// I2S link bundle for audio_serial_parallel_serdes: word select, serial in/out,
// the parallel receive words, the parallel transmit words and transmit slot status.
interface audio_serial_parallel_serdes_if;
    logic        lrck;
    logic        dat;
    logic        datOut;
    logic [15:0] outl;
    logic [15:0] outr;
    logic [15:0] inl;
    logic [15:0] inr;
    logic [3:0]  tx_bit_idx;
    logic        tx_active;

    // Drives the link: the I2S source and the parallel transmit words.
    modport master (
        output lrck, dat, inl, inr,
        input  datOut, outl, outr, tx_bit_idx, tx_active
    );

    // The serdes itself.
    modport slave (
        input  lrck, dat, inl, inr,
        output datOut, outl, outr, tx_bit_idx, tx_active
    );
endinterface

// File: rtl/audio_serial_parallel_serdes.sv
// 16-bit I2S receiver and transmitter clocked by bck, with one-slot I2S delay.
// Define AUDIO_LOOPBACK_EN to retransmit the received words instead of inl/inr.
module audio_serial_parallel_serdes (
    input  logic bck,
    input  logic rst,
    audio_serial_parallel_serdes_if.slave aud
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'd15;

    // Receive side
    state_t      rx_state;
    logic        lrck_q;
    logic [3:0]  rx_cnt;
    logic [14:0] rx_sr;
    logic [15:0] rx_word;
    logic [15:0] outl_q;
    logic [15:0] outr_q;
    logic        ws_edge;

    // Transmit side
    state_t      tx_state;
    logic [15:0] tx_src;
    logic [15:0] tx_word;
    logic [3:0]  tx_idx_q;
    logic        tx_active_q;
    logic        dat_out_q;

    assign ws_edge = aud.lrck ^ lrck_q;
    // The 16th bit is taken straight from dat so the word is ready on that edge.
    assign rx_word = {rx_sr, aud.dat};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the order of the statements.
    always_ff @(posedge bck) begin
        if (rst) begin
            lrck_q   <= aud.lrck;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_sr    <= '0;
            outl_q   <= '0;
            outr_q   <= '0;
        end else begin
            lrck_q <= aud.lrck;
            if (ws_edge) begin
                // Delay slot: dat is not part of the word, any partial word is dropped.
                rx_state <= SHIFT;
                rx_cnt   <= '0;
                rx_sr    <= '0;
            end else begin
                case (rx_state)
                    SHIFT: begin
                        rx_sr <= rx_word[14:0];
                        if (rx_cnt == LAST_BIT) begin
                            rx_state <= GAP;
                            rx_cnt   <= '0;
                            if (lrck_q) begin
                                outr_q <= rx_word;
                            end else begin
                                outl_q <= rx_word;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                    IDLE, GAP: begin
                        rx_cnt <= '0;
                    end
                    default: begin
                        rx_state <= IDLE;
                        rx_cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef AUDIO_LOOPBACK_EN
    logic unused_tx_inputs;
    assign unused_tx_inputs = ^{aud.inl, aud.inr};

    // Registered receive words before this edge's update: one frame of latency.
    always_comb begin
        tx_src = aud.lrck ? outr_q : outl_q;
    end
`else
    always_comb begin
        tx_src = aud.lrck ? aud.inr : aud.inl;
    end
`endif

    // tx_idx_q names the bit datOut carries from the next falling edge onward.
    always_ff @(posedge bck) begin
        if (rst) begin
            tx_state    <= IDLE;
            tx_word     <= '0;
            tx_idx_q    <= '0;
            tx_active_q <= 1'b0;
        end else if (ws_edge) begin
            tx_state    <= SHIFT;
            tx_word     <= tx_src;
            tx_idx_q    <= LAST_BIT;
            tx_active_q <= 1'b1;
        end else begin
            case (tx_state)
                SHIFT: begin
                    if (tx_idx_q == 4'd0) begin
                        tx_state    <= GAP;
                        tx_active_q <= 1'b0;
                    end else begin
                        tx_idx_q <= tx_idx_q - 4'd1;
                    end
                end
                IDLE, GAP: begin
                    tx_idx_q    <= '0;
                    tx_active_q <= 1'b0;
                end
                default: begin
                    tx_state    <= IDLE;
                    tx_idx_q    <= '0;
                    tx_active_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the falling-edge output flop has no reset of its own; it follows
    // tx_active_q, which reset clears, so datOut is 0 from the next falling edge.
    always_ff @(negedge bck) begin
        dat_out_q <= tx_active_q ? tx_word[tx_idx_q] : 1'b0;
    end

    assign aud.datOut     = dat_out_q;
    assign aud.outl       = outl_q;
    assign aud.outr       = outr_q;
    assign aud.tx_bit_idx = tx_idx_q;
    assign aud.tx_active  = tx_active_q;

endmodule

// File: tb/tb_audio_serial_parallel_serdes.sv
// Directed bench for audio_serial_parallel_serdes: I2S frames with gaps, truncated
// words, mid-word reset and transmit slot timing (expectations follow AUDIO_LOOPBACK_EN).
module tb_audio_serial_parallel_serdes;
    logic bck;
    logic rst;
    int   tests;
    int   fails;

    audio_serial_parallel_serdes_if aud ();

    audio_serial_parallel_serdes dut (
        .bck (bck),
        .rst (rst),
        .aud (aud.slave)
    );

    initial begin
        bck = 1'b0;
        forever #5 bck = ~bck;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bck slot: inputs change on the falling edge, outputs are read 1 ns after rising.
    task automatic slot(input logic l, input logic d);
        @(negedge bck);
        aud.lrck = l;
        aud.dat  = d;
        @(posedge bck);
        #1;
    endtask

    // Delay slot, nbits data bits MSB first, then gap slots with dat held high.
    task automatic frame(input string name, input logic ch, input logic [15:0] word,
                         input int nbits, input int gap,
                         input logic chk_tx, input logic [15:0] tx_exp,
                         input logic [15:0] pre_l, input logic [15:0] pre_r,
                         input logic [15:0] post_l, input logic [15:0] post_r);
        slot(ch, 1'b1);
        if (chk_tx) begin
            check({name, " delay datOut"}, {15'd0, aud.datOut}, 16'd0);
            check({name, " delay idx"}, {12'd0, aud.tx_bit_idx}, 16'd15);
            check({name, " delay active"}, {15'd0, aud.tx_active}, 16'd1);
        end
        for (int k = 1; k <= nbits; k++) begin
            slot(ch, word[16-k]);
            if (chk_tx) begin
                check($sformatf("%s datOut bit%0d", name, 16 - k), {15'd0, aud.datOut},
                      {15'd0, tx_exp[16-k]});
                if (k <= 15)
                    check($sformatf("%s idx k%0d", name, k), {12'd0, aud.tx_bit_idx},
                          16'(15 - k));
            end
            if (k == 15 || (k == nbits && nbits < 16)) begin
                check({name, " hold outl"}, aud.outl, pre_l);
                check({name, " hold outr"}, aud.outr, pre_r);
            end
            if (k == 16) begin
                check({name, " outl"}, aud.outl, post_l);
                check({name, " outr"}, aud.outr, post_r);
                if (chk_tx) begin
                    check({name, " end active"}, {15'd0, aud.tx_active}, 16'd0);
                    check({name, " end idx"}, {12'd0, aud.tx_bit_idx}, 16'd0);
                end
            end
        end
        for (int g = 0; g < gap; g++) begin
            slot(ch, 1'b1);
            check($sformatf("%s gap%0d outl", name, g), aud.outl, post_l);
            check($sformatf("%s gap%0d outr", name, g), aud.outr, post_r);
            if (chk_tx) begin
                check($sformatf("%s gap%0d datOut", name, g), {15'd0, aud.datOut}, 16'd0);
                check($sformatf("%s gap%0d active", name, g), {15'd0, aud.tx_active}, 16'd0);
            end
        end
    endtask

    logic [15:0] tx_first;
    logic [15:0] tx_second;

    initial begin
        tests = 0;
        fails = 0;
`ifdef AUDIO_LOOPBACK_EN
        tx_first  = 16'hCACA;
        tx_second = 16'h5ACA;
`else
        tx_first  = 16'hCACA;
        tx_second = 16'hCACA;
`endif
        rst     = 1'b1;
        aud.lrck = 1'b0;
        aud.dat  = 1'b0;
        aud.inl  = 16'hA5A5;
        aud.inr  = 16'hCACA;

        slot(1'b0, 1'b0);
        slot(1'b0, 1'b0);
        check("reset outl", aud.outl, 16'd0);
        check("reset outr", aud.outr, 16'd0);
        check("reset active", {15'd0, aud.tx_active}, 16'd0);
        check("reset idx", {12'd0, aud.tx_bit_idx}, 16'd0);
        check("reset datOut", {15'd0, aud.datOut}, 16'd0);

        rst = 1'b0;
        slot(1'b0, 1'b1);
        slot(1'b0, 1'b1);
        check("idle outl", aud.outl, 16'd0);
        check("idle datOut", {15'd0, aud.datOut}, 16'd0);
        check("idle active", {15'd0, aud.tx_active}, 16'd0);

        frame("r_caca", 1'b1, 16'hCACA, 16, 5, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'hCACA);
        frame("l_bf7f", 1'b0, 16'hBF7F, 16, 2, 1'b0, 16'h0, 16'h0000, 16'hCACA, 16'hBF7F, 16'hCACA);
        frame("r_5aca", 1'b1, 16'h5ACA, 16, 2, 1'b1, tx_first, 16'hBF7F, 16'hCACA, 16'hBF7F, 16'h5ACA);
        frame("l_7f7f", 1'b0, 16'h7F7F, 16, 2, 1'b0, 16'h0, 16'hBF7F, 16'h5ACA, 16'h7F7F, 16'h5ACA);
        frame("r_9eca", 1'b1, 16'h9ECA, 16, 2, 1'b1, tx_second, 16'h7F7F, 16'h5ACA, 16'h7F7F, 16'h9ECA);
        frame("l_7f7f_b", 1'b0, 16'h7F7F, 16, 0, 1'b0, 16'h0, 16'h7F7F, 16'h9ECA, 16'h7F7F, 16'h9ECA);

        // Right word cut off after 9 bits, then a full left word.
        frame("r_trunc", 1'b1, 16'hFFFF, 9, 0, 1'b0, 16'h0, 16'h7F7F, 16'h9ECA, 16'h7F7F, 16'h9ECA);
        frame("l_1357", 1'b0, 16'h1357, 16, 1, 1'b0, 16'h0, 16'h7F7F, 16'h9ECA, 16'h1357, 16'h9ECA);

        // Reset in the middle of a right word.
        frame("r_prerst", 1'b1, 16'hFFFF, 7, 0, 1'b0, 16'h0, 16'h1357, 16'h9ECA, 16'h1357, 16'h9ECA);
        rst = 1'b1;
        slot(1'b1, 1'b1);
        check("midrst outl", aud.outl, 16'd0);
        check("midrst outr", aud.outr, 16'd0);
        check("midrst active", {15'd0, aud.tx_active}, 16'd0);
        check("midrst idx", {12'd0, aud.tx_bit_idx}, 16'd0);
        slot(1'b1, 1'b1);
        check("midrst datOut", {15'd0, aud.datOut}, 16'd0);
        rst = 1'b0;
        slot(1'b1, 1'b1);
        slot(1'b1, 1'b1);
        check("postrst outr", aud.outr, 16'd0);
        check("postrst active", {15'd0, aud.tx_active}, 16'd0);
        frame("l_2468", 1'b0, 16'h2468, 16, 1, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h2468, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/audio_serial_parallel_serdes.md
AUDIO_SERIAL_PARALLEL_SERDES -- requirements
Module: audio_serial_parallel_serdes

Interface
REQ-001 The design SHALL have one clock; reset is synchronous and active-high.
REQ-002 The design SHALL have these ports:
- bck, in, 1, I2S bit clock and sole clock.
- rst, in, 1, synchronous active-high reset, sampled on rising bck.
- lrck, in, 1, word select: 0 = left, 1 = right.
- dat, in, 1, serial audio in, MSB first.
- datOut, out, 1, serial audio out, I2S format.
- outl, out, 16, last complete left word received.
- outr, out, 16, last complete right word received.
- inl, in, 16, left word to transmit; ignored when loopback is enabled.
- inr, in, 16, right word to transmit; ignored when loopback is enabled.
- tx_bit_idx, out, 4, index of the bit currently on datOut (15 = MSB).
- tx_active, out, 1, high while datOut carries one of the 16 data bits.

Function
REQ-003 The receive side SHALL sample lrck and dat on rising bck and keep lrck_q, the previous lrck sample.
REQ-004 A word-select edge SHALL be any rising bck where lrck differs from lrck_q; that edge is the I2S delay slot, and its dat is ignored.
REQ-005 On the 16 rising edges after the delay slot, the receive side SHALL shift dat in MSB first.
REQ-006 On the 16th data edge, the receive side SHALL load the assembled word into outl (lrck=0) or outr (lrck=1); the other output SHALL hold.
REQ-007 After 16 bits, further edges until the next word-select edge (gap slots, any count including 0) SHALL be ignored.
REQ-008 If a word-select edge arrives before 16 bits are received, the partial word SHALL be discarded, outputs SHALL hold, and a new word SHALL start.
REQ-009 Each side SHALL use the states IDLE (after reset, until the first word-select edge), SHIFT (bits 15..0) and GAP.
- IDLE -> SHIFT on a word-select edge.
- SHIFT -> GAP after bit 0.
- GAP or SHIFT -> SHIFT on a word-select edge.
REQ-010 The transmit side SHALL detect the same word-select edge and latch the source word for that channel.
- Source with loopback: outl/outr as they stand at that edge.
- Source without loopback: inl/inr.
REQ-011 datOut SHALL carry the latched word MSB first, in the same 16 slots the receive side uses, with the same one-slot I2S delay.
REQ-012 datOut SHALL be 0 in the delay slot, in gap slots and in IDLE.
REQ-013 datOut SHALL change only on falling bck, so downstream rising-edge sampling sees stable data.
REQ-014 tx_active SHALL be 1 exactly during the 16 data slots; tx_bit_idx SHALL count 15 down to 0 during those slots and SHALL be 0 otherwise.
REQ-015 In loopback, a word SHALL appear on datOut in the next same-channel slot after it was received: one frame of latency.

Reset
REQ-016 While rst=1 at rising bck, the design SHALL force the following:
- outl=0, outr=0, both shift registers 0.
- Bit counters 0, both sides in IDLE.
- lrck_q loaded with the current lrck, so no word-select edge is detected during the reset cycle.
- tx_active=0, tx_bit_idx=0.
- datOut=0 from the next falling edge.
REQ-017 Reset in mid-word SHALL discard the word; outputs SHALL NOT update from the pre-reset partial word.

Configuration
REQ-018 With AUDIO_LOOPBACK_EN defined, the transmit source SHALL be outl/outr and inl/inr SHALL be unused. Without it, the transmit source SHALL be inl/inr. The ports SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Frame with no gap, lrck 0->1, bits 1100101011001010 -> outr=0xCACA after the 16th data edge; outl stays 0.
- Frame with a 5-slot gap, then lrck 1->0 and bits 1011111101111111 -> outl=0xBF7F; outr holds 0xCACA through the gap.
- Gap sequence right 0x5ACA, left 0x7F7F, right 0x9ECA (2-slot gap), left 0x7F7F -> each output updates only at its own 16th bit.
- Loopback build -> datOut in the 2nd right frame equals 0xCACA, MSB in the slot after the delay slot; datOut=0 in gap slots; tx_bit_idx runs 15..0.
- lrck toggles after 9 bits -> outputs unchanged; the next full word is captured correctly.
- rst asserted mid-word -> all outputs 0; the first word-select edge after release is captured normally.
